// File: rtl/divider_pkg.sv
// Shared constants and FSM encoding for the 64-bit restoring divider.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package divider_pkg;

   localparam int OP_W  = 64;          // operand width
   localparam int R_W   = 2*OP_W + 1;  // working register: 65-bit partial remainder + 64-bit quotient field
   localparam int CNT_W = 7;           // iteration counter, must hold OP_W

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      OPSTART = 3'd1,
      SHIFT   = 3'd2,
      SUB     = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Latency: combinational.
// Backpressure: none (pure combinational).
module cla64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        ci,
   output logic [63:0] sum,
   output logic        co
);

   logic [63:0] g;
   logic [63:0] p;
   logic [63:0] c;
   logic [15:0] gg;
   logic [15:0] gp;
   logic [16:0] gc;

   // Per-bit generate/propagate, per-group lookahead, carries into every bit
   always_comb begin
      g     = a & b;
      p     = a ^ b;
      gg    = '0;
      gp    = '0;
      gc    = '0;
      c     = '0;
      gc[0] = ci;
      for (int i = 0; i < 16; i++) begin
         gg[i]     = g[4*i+3]
                   | (p[4*i+3] & g[4*i+2])
                   | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                   | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
         gp[i]     = &p[4*i +: 4];
         gc[i+1]   = gg[i] | (gp[i] & gc[i]);
         c[4*i]    = gc[i];
         c[4*i+1]  = g[4*i] | (p[4*i] & gc[i]);
         c[4*i+2]  = g[4*i+1]
                   | (p[4*i+1] & g[4*i])
                   | (p[4*i+1] & p[4*i] & gc[i]);
         c[4*i+3]  = g[4*i+2]
                   | (p[4*i+2] & g[4*i+1])
                   | (p[4*i+2] & p[4*i+1] & g[4*i])
                   | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
      end
   end

   assign sum = p ^ c;
   assign co  = gc[16];

endmodule

// File: rtl/divider.sv
// Unsigned 64/64 restoring radix-2 divider, one quotient bit per SHIFT+SUB pair.
// Latency: op_done in the cycle after edge k+129 (k = start edge); k+1 for a zero divisor.
// Backpressure: none; op_start is ignored unless IDLE, op_clear aborts from any state.
module divider
   import divider_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            op_start,
   input  logic            op_clear,
   input  logic [OP_W-1:0] dividend,
   input  logic [OP_W-1:0] divisor,
   output logic            op_done,
   output logic [OP_W-1:0] quotient,
   output logic [OP_W-1:0] remainder,
   output logic            div_by_zero
);

   state_t           state_q, state_d;
   logic [R_W-1:0]   r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]  dvsr_q, dvsr_d;
   logic             dbz_q, dbz_d;
   logic             op_done_q, op_done_d;

   logic [OP_W-1:0]  sub_dif;
   logic             sub_co;

   // Trial subtraction of the latched divisor from the low 64 bits of the partial remainder
   cla64 u_sub (
      .a   (r_q[2*OP_W-1:OP_W]),
      .b   (~dvsr_q),
      .ci  (1'b1),
      .sum (sub_dif),
      .co  (sub_co)
   );

   // Next-state and datapath: clear wins everywhere, otherwise step the FSM
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      dvsr_d  = dvsr_q;
      dbz_d   = dbz_q;
      if (op_clear) begin
         state_d = IDLE;
         r_d     = '0;
         cnt_d   = '0;
         dvsr_d  = '0;
         dbz_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (op_start) state_d = OPSTART;
            end
            OPSTART: begin
               dvsr_d = divisor;
               cnt_d  = CNT_W'(OP_W);
               if (divisor == '0) begin
                  // All-ones quotient and the dividend as remainder flag the fault
                  r_d     = {1'b0, dividend, {OP_W{1'b1}}};
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  r_d     = {{(OP_W+1){1'b0}}, dividend};
                  dbz_d   = 1'b0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               r_d     = {r_q[R_W-2:0], 1'b0};
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = SUB;
            end
            SUB: begin
               // Bit 128 set means the partial remainder already exceeds any 64-bit divisor
               if (r_q[R_W-1] || sub_co) begin
                  r_d[R_W-1:OP_W] = {1'b0, sub_dif};
                  r_d[0]          = 1'b1;
               end
               state_d = (cnt_q == '0) ? DONE : SHIFT;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Completion pulse registered alongside the DONE state
   always_comb begin
      op_done_d = (state_d == DONE);
   end

   // State, datapath and flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         r_q       <= '0;
         cnt_q     <= '0;
         dvsr_q    <= '0;
         dbz_q     <= 1'b0;
         op_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         cnt_q     <= cnt_d;
         dvsr_q    <= dvsr_d;
         dbz_q     <= dbz_d;
         op_done_q <= op_done_d;
      end
   end

   assign op_done     = op_done_q;
   assign quotient    = r_q[OP_W-1:0];
   assign remainder   = r_q[2*OP_W-1:OP_W];
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: scoreboard of expected results, per-scenario tasks.
module tb_divider;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        op_start;
   logic        op_clear;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        op_done;
   logic [63:0] quotient;
   logic [63:0] remainder;
   logic        div_by_zero;

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   divider dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .op_start    (op_start),
      .op_clear    (op_clear),
      .dividend    (dividend),
      .divisor     (divisor),
      .op_done     (op_done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Push the reference result, pulse op_start over one rising edge (the start edge).
   // Entered and left at a falling edge; on exit the start edge has just passed.
   task automatic start_op(input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      if (b == 64'd0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 129;
      end
      sb.push_back(e);
      dividend = a;
      divisor  = b;
      op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
   endtask

   // Count rising edges after the start edge until op_done is seen (bounded)
   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (op_done !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (op_done === 1'b1) n++;
      end
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if ({op_done, div_by_zero} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {op_done, div_by_zero}); end
      n_cmp++; if ({quotient, remainder} !== 128'd0) begin n_err++; $display("FAIL reset_results: got q=%h r=%h want 0", quotient, remainder); end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if ({op_done, div_by_zero, quotient, remainder} !== 130'd0) begin n_err++; $display("FAIL reset_release: outputs not zero q=%h r=%h", quotient, remainder); end
   endtask

   task automatic test_basic();
      exp_t e; int lat;
      start_op(64'd100, 64'd7);
      wait_done(0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL basic_latency: got %0d edges want %0d", lat, e.lat); end
      n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL basic_quotient: got %0d want %0d", quotient, e.q); end
      n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL basic_remainder: got %0d want %0d", remainder, e.r); end
      n_cmp++; if (div_by_zero !== e.dbz) begin n_err++; $display("FAIL basic_dbz: got %b want %b", div_by_zero, e.dbz); end
      @(negedge clk);
      n_cmp++; if (op_done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: op_done still %b", op_done); end
      repeat (5) @(negedge clk);
      n_cmp++; if (quotient !== e.q || remainder !== e.r) begin n_err++; $display("FAIL basic_hold: got q=%0d r=%0d want q=%0d r=%0d", quotient, remainder, e.q, e.r); end
   endtask

   task automatic test_patterns();
      logic [63:0] dvd [3];
      logic [63:0] dvs [3];
      exp_t e; int lat;
      dvd[0] = 64'd5; dvs[0] = 64'd9;
      dvd[1] = '1;    dvs[1] = '1;
      dvd[2] = '1;    dvs[2] = 64'd1;
      for (int i = 0; i < 3; i++) begin
         start_op(dvd[i], dvs[i]);
         wait_done(0, lat);
         e = sb.pop_front();
         n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL pattern%0d_latency: got %0d want %0d", i, lat, e.lat); end
         n_cmp++; if (quotient !== e.q || remainder !== e.r) begin n_err++; $display("FAIL pattern%0d_result: got q=%h r=%h want q=%h r=%h", i, quotient, remainder, e.q, e.r); end
         @(negedge clk);
      end
   endtask

   task automatic test_div_zero();
      exp_t e; int lat;
      start_op(64'd123, 64'd0);
      wait_done(0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL dbz_latency: got %0d want %0d", lat, e.lat); end
      n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL dbz_quotient: got %h want %h", quotient, e.q); end
      n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL dbz_remainder: got %0d want %0d", remainder, e.r); end
      n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
      @(negedge clk);
      n_cmp++; if (op_done !== 1'b0) begin n_err++; $display("FAIL dbz_done_width: op_done still %b", op_done); end
   endtask

   task automatic test_clear();
      exp_t e; int lat; int n;
      start_op(64'd100, 64'd7);
      repeat (39) @(negedge clk);
      e = sb.pop_front();
      op_clear = 1'b1;
      @(negedge clk);
      op_clear = 1'b0;
      n_cmp++; if ({quotient, remainder} !== 128'd0) begin n_err++; $display("FAIL clear_results: got q=%h r=%h want 0", quotient, remainder); end
      n_cmp++; if ({op_done, div_by_zero} !== 2'b00) begin n_err++; $display("FAIL clear_flags: got %b want 00", {op_done, div_by_zero}); end
      count_done(200, n);
      n_cmp++; if (n !== 0) begin n_err++; $display("FAIL clear_no_done: got %0d pulses want 0", n); end
      start_op(64'd100, 64'd7);
      wait_done(0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat || quotient !== e.q || remainder !== e.r) begin n_err++; $display("FAIL clear_restart: got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d", lat, quotient, remainder, e.lat, e.q, e.r); end
      @(negedge clk);
   endtask

   task automatic test_start_clear_idle();
      int n;
      dividend = 64'd50;
      divisor  = 64'd5;
      op_start = 1'b1;
      op_clear = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      op_clear = 1'b0;
      n_cmp++; if (quotient !== 64'd0) begin n_err++; $display("FAIL start_clear_quotient: got %0d want 0", quotient); end
      count_done(200, n);
      n_cmp++; if (n !== 0) begin n_err++; $display("FAIL start_clear_no_op: got %0d pulses want 0", n); end
   endtask

   task automatic test_restart_busy();
      exp_t e; int lat; int n;
      start_op(64'd1000, 64'd3);
      lat = 0;
      repeat (10) begin @(negedge clk); lat++; end
      dividend = 64'd7;
      divisor  = 64'd0;
      op_start = 1'b1;
      @(negedge clk);
      lat++;
      op_start = 1'b0;
      wait_done(lat, lat);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL busy_latency: got %0d want %0d", lat, e.lat); end
      n_cmp++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin n_err++; $display("FAIL busy_result: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
      count_done(200, n);
      n_cmp++; if (n !== 0) begin n_err++; $display("FAIL busy_extra_done: got %0d pulses want 0", n); end
   endtask

   task automatic test_async_reset();
      exp_t e; int n;
      start_op({$urandom, $urandom}, 64'd12345);
      repeat (50) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if ({quotient, remainder} !== 128'd0) begin n_err++; $display("FAIL areset_results: got q=%h r=%h want 0", quotient, remainder); end
      n_cmp++; if ({op_done, div_by_zero} !== 2'b00) begin n_err++; $display("FAIL areset_flags: got %b want 00", {op_done, div_by_zero}); end
      e = sb.pop_front();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      count_done(200, n);
      n_cmp++; if (n !== 0) begin n_err++; $display("FAIL areset_no_done: got %0d pulses want 0", n); end
   endtask

   task automatic test_random();
      exp_t e; int lat;
      logic [63:0]  a, b;
      logic [127:0] recon;
      for (int i = 0; i < 20; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         b = b >> $urandom_range(63, 0);
         if (b == 64'd0) b = 64'd1;
         start_op(a, b);
         wait_done(0, lat);
         e = sb.pop_front();
         n_cmp++; if (lat !== e.lat || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin n_err++; $display("FAIL random%0d_model: a=%h b=%h got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h", i, a, b, lat, quotient, remainder, e.lat, e.q, e.r); end
         recon = 128'(quotient) * 128'(b) + 128'(remainder);
         n_cmp++; if (recon !== 128'(a) || !(remainder < b)) begin n_err++; $display("FAIL random%0d_identity: a=%h b=%h q=%h r=%h", i, a, b, quotient, remainder); end
         @(negedge clk);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      op_start = 1'b0;
      op_clear = 1'b0;
      dividend = '0;
      divisor  = '0;
      test_reset();
      test_basic();
      test_patterns();
      test_div_zero();
      test_clear();
      test_start_clear_idle();
      test_restart_busy();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
